// File: rtl/stage2_control.sv
// Moore sequencing controller for the fetch stage and register-file/ALU datapath.
// One instruction per pass through fetch, decode and execute. HALT holds until reset.
module stage2_control #(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] ir,
  output logic                  loadpc,
  output logic                  loadir,
  output logic                  msel,
  output logic                  mwrite,
  output logic [2:0]            readnum,
  output logic [2:0]            writenum,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            vsel,
  output logic [1:0]            ALUop,
  output logic [1:0]            shift,
  output logic [data_width-1:0] sximm8,
  output logic [data_width-1:0] sximm5,
  output logic                  halt
);

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WR_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_WR_C, S_ADDR, S_MEM_RD, S_WR_MEM, S_MEM_WR, S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_is_mov_imm;
  logic       w_is_mov_reg;
  logic       w_is_alu;
  logic       w_is_mvn;
  logic       w_is_cmp;
  logic       w_is_ldr;
  logic       w_is_str;
  logic       w_is_halt;

  assign w_opcode = ir[15:13];
  assign w_op     = ir[12:11];
  assign w_rn     = ir[10:8];
  assign w_rd     = ir[7:5];
  assign w_sh     = ir[4:3];
  assign w_rm     = ir[2:0];

  assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu     = (w_opcode == 3'b101);
  assign w_is_mvn     = w_is_alu && (w_op == 2'b11);
  assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
  assign w_is_ldr     = (w_opcode == 3'b011) && (w_op == 2'b00);
  assign w_is_str     = (w_opcode == 3'b100) && (w_op == 2'b00);
  assign w_is_halt    = (w_opcode == 3'b111);

  assign sximm8 = {{(data_width-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(data_width-5){ir[4]}}, ir[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:    w_next = S_IF1;
      S_IF1:    w_next = S_IF2;
      S_IF2:    w_next = S_UPC;
      S_UPC:    w_next = S_DEC;
      S_DEC: begin
        if (w_is_mov_imm)                   w_next = S_WR_IMM;
        else if (w_is_mov_reg || w_is_mvn)  w_next = S_GET_B;
        else if (w_is_alu || w_is_ldr || w_is_str) w_next = S_GET_A;
        else if (w_is_halt)                 w_next = S_HALT;
        else                                w_next = S_IF1;
      end
      S_WR_IMM: w_next = S_IF1;
      S_GET_A:  w_next = (w_is_ldr || w_is_str) ? S_ADDR : S_GET_B;
      // STR computes the address first, then fetches the store data into B.
      S_ADDR:   w_next = w_is_str ? S_GET_B : S_MEM_RD;
      S_GET_B:  w_next = w_is_str ? S_MEM_WR : S_EXEC;
      S_EXEC:   w_next = w_is_cmp ? S_IF1 : S_WR_C;
      S_WR_C:   w_next = S_IF1;
      S_MEM_RD: w_next = S_WR_MEM;
      S_WR_MEM: w_next = S_IF1;
      S_MEM_WR: w_next = S_IF1;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_RST;
    endcase
  end

  always_comb begin
    loadpc   = 1'b0;
    loadir   = 1'b0;
    msel     = 1'b0;
    mwrite   = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    ALUop    = 2'b00;
    shift    = 2'b00;
    halt     = 1'b0;
    case (r_state)
      S_IF2:    loadir = 1'b1;
      S_UPC:    loadpc = 1'b1;
      S_WR_IMM: begin
        writenum = w_rn;
        vsel     = 2'b01;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_is_str ? w_rd : w_rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = w_sh;
        ALUop = w_is_mov_reg ? 2'b00 : w_op;
        asel  = w_is_mov_reg || w_is_mvn;
        loads = w_is_cmp;
        loadc = !w_is_cmp;
      end
      S_WR_C: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_RD: msel = 1'b1;
      S_WR_MEM: begin
        msel     = 1'b1;
        vsel     = 2'b10;
        writenum = w_rd;
        write    = 1'b1;
      end
      S_MEM_WR: begin
        msel   = 1'b1;
        mwrite = 1'b1;
      end
      S_HALT:   halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/stage2_control.md
# stage2_control

Instruction-sequencing controller that sits directly downstream of the fetch stage (PC, instruction RAM port, instruction register). It consumes the 16-bit instruction-register output and drives the fetch stage's `loadpc`, `loadir`, `msel` and `mwrite` strobes. It also drives every load, select and write strobe of the register-file/ALU datapath. It is a Moore state machine that executes one instruction per pass through fetch → decode → execute.

## Interface
- `data_width`, 16, width of `ir` and of the sign-extended immediates.
- `clk` input 1, rising-edge clock shared with the fetch stage and datapath.
- `reset` input 1, asynchronous, active-high; the same net also clears the fetch-stage PC.
- `ir` input 16, instruction-register output from the fetch stage.
- `loadpc`, `loadir`, `msel`, `mwrite` output 1 each, fetch-stage controls (`msel`=0: PC addresses RAM, 1: datapath C[7:0]).
- `readnum`, `writenum` output 3 each, register-file read and write index.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` output 1 each, datapath strobes and selects (`asel`=1 forces A operand to 0; `bsel`=1 selects `sximm5`).
- `vsel` output 2, write-back source: 00 C, 01 `sximm8`, 10 RAM `mdata`.
- `ALUop` output 2; `shift` output 2.
- `sximm8`, `sximm5` output 16, sign-extended `ir[7:0]` and `ir[4:0]`; combinational from `ir`.
- `halt` output 1, high while in HALT.

## Operation
- Instruction fields:
  - opcode `ir[15:13]`, op `ir[12:11]`
  - Rn `ir[10:8]`, Rd `ir[7:5]`, sh `ir[4:3]`, Rm `ir[2:0]`
- Instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
  - 011/00 LDR Rd,[Rn,#imm5]
  - 100/00 STR Rd,[Rn,#imm5]
  - 111/xx HALT
  - Any other encoding is a NOP.
- States: RST, IF1, IF2, UPC, DEC, WR_IMM, GET_A, GET_B, EXEC, WR_C, ADDR, MEM_RD, WR_MEM, MEM_WR, HALT.
- Outputs are a function of state and `ir` only. Any strobe not listed for a state is 0; selects not listed are 0.
- Fetch sequence:
  - RST → IF1.
  - IF1: `msel`=0, RAM addressed by PC.
  - IF2: `msel`=0, `loadir`=1.
  - UPC: `loadpc`=1.
  - DEC: no strobes; branches on opcode/op.
- MOV imm: DEC → WR_IMM (`writenum`=Rn, `vsel`=01, `write`=1) → IF1.
- ALU operations:
  - ADD, AND, CMP: DEC → GET_A (`readnum`=Rn, `loada`).
  - MOV reg, MVN: DEC → GET_B directly; no GET_A.
  - GET_B: `readnum`=Rm, `loadb`.
  - EXEC: `shift`=sh; `ALUop`=op (00 for MOV reg); `asel`=1 for MOV reg/MVN.
  - CMP: EXEC asserts `loads`=1, `loadc`=0, then goes → IF1.
  - All others: EXEC asserts `loadc`=1, then → WR_C (`writenum`=Rd, `vsel`=00, `write`) → IF1.
- LDR:
  - DEC → GET_A (Rn).
  - ADDR: `bsel`=1, `ALUop`=00, `shift`=00, `loadc`.
  - MEM_RD: `msel`=1.
  - WR_MEM: `msel`=1, `vsel`=10, `writenum`=Rd, `write`. Then → IF1.
- STR:
  - DEC → GET_A (Rn) → ADDR.
  - GET_B: `readnum`=Rd, `loadb`.
  - MEM_WR: `msel`=1, `mwrite`=1. Then → IF1.
- HALT: DEC → HALT with `halt`=1. Stays in HALT until `reset`.
- NOP: DEC → IF1.

## Timing
- `reset` high forces RST immediately, without waiting for `clk`. All 1-bit and state-derived outputs are 0 in RST; `sximm8`/`sximm5` still follow `ir`.
- Reset mid-operation aborts the instruction. If reset arrives in MEM_WR, `mwrite` falls combinationally on the reset edge. No partial write-back occurs after reset.
- First IF1 occurs on the first rising `clk` after `reset` is released.
- `ir` holds the new instruction from the end of IF2; DEC and all later states decode it. `ir` must be stable from DEC until the next IF2.
- Cycles per instruction, IF1 to the next IF1:
  - MOV imm: 5
  - MOV reg / MVN: 7
  - CMP: 7
  - ADD / AND: 8
  - LDR: 8
  - STR: 8
  - NOP: 4
- `mwrite` is high for exactly one cycle per STR and never in any other state.
- `loadpc` is high exactly once per instruction; `loadir` is high exactly once per instruction.
- RAM read data is valid one cycle after the address is presented. This is why MEM_RD precedes WR_MEM with `msel` held at 1 in both states.

## Test plan
- Reset/fetch: hold `reset` 2 cycles with all outputs 0, then release. Expect, on consecutive cycles:
  - IF1 (`msel`=0)
  - IF2 (`loadir`=1)
  - UPC (`loadpc`=1)
  - DEC
- `ir`=16'hD3FB (MOV R3,#-5): WR_IMM asserts `writenum`=3, `vsel`=01, `write`=1 with `sximm8`=16'hFFFB. Next IF1 follows 5 cycles after the previous IF1.
- `ir`=16'hA148 (ADD R2,R1,R0 LSL#1):
  - GET_A: `readnum`=1, `loada`.
  - GET_B: `readnum`=0, `loadb`.
  - EXEC: `shift`=01, `ALUop`=00, `loadc`.
  - WR_C: `writenum`=2, `write`.
- `ir`=16'hA900 (CMP R1,R0): EXEC has `loads`=1, `loadc`=0, `ALUop`=01. `write` never asserts, and the state goes to IF1 next.
- `ir`=16'h8183 (STR R4,[R1,#3]):
  - ADDR: `bsel`=1 with `sximm5`=16'h0003.
  - GET_B: `readnum`=4.
  - MEM_WR: `msel`=1, `mwrite`=1 for one cycle.
  - Then `ir`=16'h6183 (LDR): WR_MEM has `vsel`=10, `writenum`=4, `write`=1.
- `ir`=16'hE000 (HALT): `halt`=1 held for 20 cycles with no `loadpc`/`loadir`. Separately, assert `reset` mid-MEM_WR: `mwrite` drops before the next clock edge and the block restarts at IF1.
